ah_div_pipelined_param: RTL



---
 rtl/ah_div_pipelined_param_pkg.sv | 24 ++
 rtl/ah_div_stage.sv | 65 ++++++
 rtl/ah_div_pipelined_param.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ah_div_pipelined_param_pkg.sv
// Shared helpers for the parametrised pipelined divider: latency, signed MIN and
// the special-case quotient encodings, all sized to MAX_WIDTH and truncated by the user.
package ah_div_pipelined_param_pkg;

   localparam int MAX_WIDTH = 64;

   function automatic int div_latency(input int width);
      return width + 2;
   endfunction

   function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
      return 64'd1 << (width - 1);
   endfunction

   function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
      return ~64'd0 >> (MAX_WIDTH - width);
   endfunction

   // Divide-by-zero quotient: all ones (unsigned or non-negative dividend), +1 otherwise.
   function automatic logic [MAX_WIDTH-1:0] dbz_quotient(input int width, input logic dividend_neg);
      return dividend_neg ? 64'd1 : all_ones(width);
   endfunction

endpackage

// File: rtl/ah_div_stage.sv
// One restoring-division step: shift in the next dividend bit and subtract the
// divisor magnitude when it fits, producing quotient bit WIDTH-STEP.
module ah_div_stage #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cur_valid,
   input  logic [WIDTH:0]   cur_rem,
   input  logic [WIDTH-1:0] cur_dvd,
   input  logic [WIDTH-1:0] cur_dsr,
   input  logic [WIDTH-1:0] cur_quo,
   input  logic             cur_neg_q,
   input  logic             cur_neg_r,
   input  logic             cur_dbz,
   input  logic             cur_ovf,
   input  logic [WIDTH-1:0] cur_orig,
   output logic             nxt_valid,
   output logic [WIDTH:0]   nxt_rem,
   output logic [WIDTH-1:0] nxt_dvd,
   output logic [WIDTH-1:0] nxt_dsr,
   output logic [WIDTH-1:0] nxt_quo,
   output logic             nxt_neg_q,
   output logic             nxt_neg_r,
   output logic             nxt_dbz,
   output logic             nxt_ovf,
   output logic [WIDTH-1:0] nxt_orig
);

   logic [WIDTH+1:0] shifted_s;
   logic [WIDTH+1:0] diff_s;
   logic             fits_s;
   logic [WIDTH-1:0] quo_s;

   assign shifted_s = {cur_rem, cur_dvd[WIDTH-STEP]};
   assign diff_s    = shifted_s - {2'b00, cur_dsr};
   assign fits_s    = shifted_s >= {2'b00, cur_dsr};

   // Merge this stage's quotient bit into the running quotient.
   always_comb begin
      quo_s = cur_quo;
      quo_s[WIDTH-STEP] = fits_s;
   end

   // Stage register; holds everything, valid included, while the pipeline is stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         nxt_valid <= 1'b0;
      end else if (en) begin
         nxt_valid <= cur_valid;
         nxt_rem   <= fits_s ? diff_s[WIDTH:0] : shifted_s[WIDTH:0];
         nxt_dvd   <= cur_dvd;
         nxt_dsr   <= cur_dsr;
         nxt_quo   <= quo_s;
         nxt_neg_q <= cur_neg_q;
         nxt_neg_r <= cur_neg_r;
         nxt_dbz   <= cur_dbz;
         nxt_ovf   <= cur_ovf;
         nxt_orig  <= cur_orig;
      end
   end

endmodule

// File: rtl/ah_div_pipelined_param.sv
// Parametrised pipelined divider: operand capture, WIDTH restoring stages, sign fix-up
// and special cases. A single global stall freezes every stage while out_ready is withheld.
module ah_div_pipelined_param
   import ah_div_pipelined_param_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int               LATENCY = div_latency(WIDTH);
   localparam int               STAGES  = LATENCY - 2;
   localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(signed_min(WIDTH));

   logic             stall_s, adv_s;
   logic             dvd_neg_s, dsr_neg_s;
   logic [WIDTH-1:0] dvd_mag_s, dsr_mag_s;
   logic [WIDTH-1:0] q_s, r_s;
   logic             dbz_s, ovf_s;
   logic             unused_s;

   logic             s0_valid_r, s0_neg_q_r, s0_neg_r_r, s0_dbz_r, s0_ovf_r;
   logic [WIDTH-1:0] s0_dvd_r, s0_dsr_r, s0_orig_r;
   logic             out_valid_r, div_by_zero_r, overflow_r;
   logic [WIDTH-1:0] quotient_r, remainder_r;

   logic             valid_a [0:WIDTH];
   logic [WIDTH:0]   rem_a   [0:WIDTH];
   logic [WIDTH-1:0] dvd_a   [0:WIDTH];
   logic [WIDTH-1:0] dsr_a   [0:WIDTH];
   logic [WIDTH-1:0] quo_a   [0:WIDTH];
   logic             neg_q_a [0:WIDTH];
   logic             neg_r_a [0:WIDTH];
   logic             dbz_a   [0:WIDTH];
   logic             ovf_a   [0:WIDTH];
   logic [WIDTH-1:0] orig_a  [0:WIDTH];

   assign stall_s  = out_valid_r & ~out_ready;
   assign adv_s    = ~stall_s;
   assign in_ready = adv_s;

   assign dvd_neg_s = in_signed & dividend[WIDTH-1];
   assign dsr_neg_s = in_signed & divisor[WIDTH-1];
   assign dvd_mag_s = dvd_neg_s ? ({WIDTH{1'b0}} - dividend) : dividend;
   assign dsr_mag_s = dsr_neg_s ? ({WIDTH{1'b0}} - divisor) : divisor;

   // Stage 0: capture magnitudes, result signs and special-case flags on accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s0_valid_r <= 1'b0;
      end else if (adv_s) begin
         s0_valid_r <= in_valid;
         s0_dvd_r   <= dvd_mag_s;
         s0_dsr_r   <= dsr_mag_s;
         s0_neg_q_r <= dvd_neg_s ^ dsr_neg_s;
         s0_neg_r_r <= dvd_neg_s;
         s0_dbz_r   <= (divisor == {WIDTH{1'b0}});
         s0_ovf_r   <= in_signed & (dividend == MIN_VAL) & (divisor == {WIDTH{1'b1}});
         s0_orig_r  <= dividend;
      end
   end

   assign valid_a[0] = s0_valid_r;
   assign rem_a[0]   = {(WIDTH+1){1'b0}};
   assign dvd_a[0]   = s0_dvd_r;
   assign dsr_a[0]   = s0_dsr_r;
   assign quo_a[0]   = {WIDTH{1'b0}};
   assign neg_q_a[0] = s0_neg_q_r;
   assign neg_r_a[0] = s0_neg_r_r;
   assign dbz_a[0]   = s0_dbz_r;
   assign ovf_a[0]   = s0_ovf_r;
   assign orig_a[0]  = s0_orig_r;

   for (genvar k = 1; k <= STAGES; k++) begin : g_stage
      ah_div_stage #(.WIDTH(WIDTH), .STEP(k)) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (adv_s),
         .cur_valid (valid_a[k-1]),
         .cur_rem   (rem_a[k-1]),
         .cur_dvd   (dvd_a[k-1]),
         .cur_dsr   (dsr_a[k-1]),
         .cur_quo   (quo_a[k-1]),
         .cur_neg_q (neg_q_a[k-1]),
         .cur_neg_r (neg_r_a[k-1]),
         .cur_dbz   (dbz_a[k-1]),
         .cur_ovf   (ovf_a[k-1]),
         .cur_orig  (orig_a[k-1]),
         .nxt_valid (valid_a[k]),
         .nxt_rem   (rem_a[k]),
         .nxt_dvd   (dvd_a[k]),
         .nxt_dsr   (dsr_a[k]),
         .nxt_quo   (quo_a[k]),
         .nxt_neg_q (neg_q_a[k]),
         .nxt_neg_r (neg_r_a[k]),
         .nxt_dbz   (dbz_a[k]),
         .nxt_ovf   (ovf_a[k]),
         .nxt_orig  (orig_a[k])
      );
   end

   // The final remainder is always below the divisor, so its top bit carries nothing.
   assign unused_s = ^{dvd_a[WIDTH], dsr_a[WIDTH], rem_a[WIDTH][WIDTH]};

   // Sign fix-up of the magnitudes, overridden by the divide-by-zero and overflow encodings.
   always_comb begin
      q_s   = {WIDTH{1'b0}};
      r_s   = {WIDTH{1'b0}};
      dbz_s = dbz_a[WIDTH];
      ovf_s = 1'b0;
      if (dbz_a[WIDTH]) begin
         q_s = WIDTH'(dbz_quotient(WIDTH, neg_r_a[WIDTH]));
         r_s = orig_a[WIDTH];
      end else if (ovf_a[WIDTH]) begin
         q_s   = MIN_VAL;
         r_s   = {WIDTH{1'b0}};
         ovf_s = 1'b1;
      end else begin
         q_s = neg_q_a[WIDTH] ? ({WIDTH{1'b0}} - quo_a[WIDTH]) : quo_a[WIDTH];
         r_s = neg_r_a[WIDTH] ? ({WIDTH{1'b0}} - rem_a[WIDTH][WIDTH-1:0]) : rem_a[WIDTH][WIDTH-1:0];
      end
   end

   // Output register; frozen while the consumer stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_r   <= 1'b0;
         quotient_r    <= {WIDTH{1'b0}};
         remainder_r   <= {WIDTH{1'b0}};
         div_by_zero_r <= 1'b0;
         overflow_r    <= 1'b0;
      end else if (adv_s) begin
         out_valid_r   <= valid_a[WIDTH];
         quotient_r    <= q_s;
         remainder_r   <= r_s;
         div_by_zero_r <= dbz_s;
         overflow_r    <= ovf_s;
      end
   end

   assign out_valid   = out_valid_r;
   assign quotient    = quotient_r;
   assign remainder   = remainder_r;
   assign div_by_zero = div_by_zero_r;
   assign overflow    = overflow_r;

endmodule
